// File: rtl/gpu_rect_writer_if.sv
// Request handshake and GPU write-port command bus for the rectangle writer.
// The slave modport is the writer itself; the master modport is whoever issues fill requests.
interface gpu_rect_writer_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_x;
  logic [5:0]  req_y;
  logic [6:0]  req_w;
  logic [5:0]  req_h;
  logic [2:0]  req_off_x;
  logic [2:0]  req_off_y;
  logic [7:0]  req_glyph;
  logic [11:0] req_primary;
  logic [11:0] req_secondary;
  logic [6:0]  gpu_clk_en;
  logic        gpu_wren;
  logic [31:0] gpu_address;
  logic [31:0] gpu_data;
  logic        busy;
  logic        done;

  modport master (
    output req_valid, req_x, req_y, req_w, req_h, req_off_x, req_off_y,
           req_glyph, req_primary, req_secondary,
    input  req_ready, gpu_clk_en, gpu_wren, gpu_address, gpu_data, busy, done
  );

  modport slave (
    input  req_valid, req_x, req_y, req_w, req_h, req_off_x, req_off_y,
           req_glyph, req_primary, req_secondary,
    output req_ready, gpu_clk_en, gpu_wren, gpu_address, gpu_data, busy, done
  );
endinterface

// File: rtl/gpu_rect_writer.sv
// Rectangle fill command issuer: walks the clipped block rectangle row-major and
// issues one 7-phase GPU write slot per 8x8 block.
module gpu_rect_writer #(
  parameter int GRID_W = 72,
  parameter int GRID_H = 54
) (
  input  logic              clk,
  input  logic              rst,
  gpu_rect_writer_if.slave  bus
);

  localparam logic [7:0] GW8 = 8'(GRID_W);
  localparam logic [6:0] GH7 = 7'(GRID_H);

  typedef enum logic [1:0] {IDLE, SETUP, ISSUE, DONE} state_t;

  state_t      r_state;
  logic [6:0]  r_x, r_w, r_cur_x;
  logic [5:0]  r_y, r_h, r_cur_y;
  logic [2:0]  r_off_x, r_off_y, r_phase;
  logic [7:0]  r_glyph;
  logic [11:0] r_prim, r_sec;
  logic [7:0]  r_x_end;
  logic [6:0]  r_y_end;
  logic [6:0]  r_clk_en;
  logic        r_wren, r_busy, r_done;
  logic [31:0] r_addr, r_data;

  // Widened sums so a rectangle running past the grid edge clips instead of wrapping.
  logic [7:0] w_x_sum, w_x_end, w_nx;
  logic [6:0] w_y_sum, w_y_end, w_ny;
  logic       w_empty;

  assign w_x_sum = {1'b0, r_x} + {1'b0, r_w};
  assign w_y_sum = {1'b0, r_y} + {1'b0, r_h};
  assign w_x_end = (w_x_sum > GW8) ? GW8 : w_x_sum;
  assign w_y_end = (w_y_sum > GH7) ? GH7 : w_y_sum;
  assign w_nx    = {1'b0, r_cur_x} + 8'd1;
  assign w_ny    = {1'b0, r_cur_y} + 7'd1;
  assign w_empty = (r_w == 7'd0) || (r_h == 6'd0) ||
                   ({1'b0, r_x} >= GW8) || ({1'b0, r_y} >= GH7);

  function automatic logic [31:0] mk_addr(input logic [6:0] x, input logic [5:0] y,
                                          input logic [2:0] ox, input logic [2:0] oy);
    return {1'b1, 12'b0, x, y, ox, oy};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_x      <= '0;  r_y     <= '0;  r_w     <= '0;  r_h <= '0;
      r_off_x  <= '0;  r_off_y <= '0;  r_glyph <= '0;
      r_prim   <= '0;  r_sec   <= '0;
      r_x_end  <= '0;  r_y_end <= '0;
      r_cur_x  <= '0;  r_cur_y <= '0;  r_phase <= '0;
      r_clk_en <= '0;  r_wren  <= 1'b0;
      r_addr   <= '0;  r_data  <= '0;
      r_busy   <= 1'b0; r_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.req_valid) begin
            r_x     <= bus.req_x;      r_y     <= bus.req_y;
            r_w     <= bus.req_w;      r_h     <= bus.req_h;
            r_off_x <= bus.req_off_x;  r_off_y <= bus.req_off_y;
            r_glyph <= bus.req_glyph;
            r_prim  <= bus.req_primary;
            r_sec   <= bus.req_secondary;
            r_busy  <= 1'b1;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_x_end <= w_x_end;
          r_y_end <= w_y_end;
          if (w_empty) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cur_x  <= r_x;
            r_cur_y  <= r_y;
            r_phase  <= 3'd0;
            r_clk_en <= 7'h01;
            r_wren   <= 1'b1;
            r_addr   <= mk_addr(r_x, r_y, r_off_x, r_off_y);
            r_data   <= {r_glyph, r_sec, r_prim};
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_phase != 3'd6) begin
            r_phase  <= r_phase + 3'd1;
            r_clk_en <= r_clk_en << 1;
          end else if (w_nx < r_x_end) begin
            r_cur_x  <= w_nx[6:0];
            r_phase  <= 3'd0;
            r_clk_en <= 7'h01;
            r_addr   <= mk_addr(w_nx[6:0], r_cur_y, r_off_x, r_off_y);
          end else if (w_ny < r_y_end) begin
            r_cur_x  <= r_x;
            r_cur_y  <= w_ny[5:0];
            r_phase  <= 3'd0;
            r_clk_en <= 7'h01;
            r_addr   <= mk_addr(r_x, w_ny[5:0], r_off_x, r_off_y);
          end else begin
            r_clk_en <= '0;
            r_wren   <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (r_state == IDLE) && !rst;
  assign bus.gpu_clk_en  = r_clk_en;
  assign bus.gpu_wren    = r_wren;
  assign bus.gpu_address = r_addr;
  assign bus.gpu_data    = r_data;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_gpu_rect_writer.sv
// Directed bench for gpu_rect_writer: cycle-exact traces of slots, clipping,
// empty requests, mid-slot reset and request back-pressure.
module tb_gpu_rect_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  gpu_rect_writer_if bus();

  gpu_rect_writer #(.GRID_W(72), .GRID_H(54)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return {21'b0, bus.req_ready, bus.busy, bus.done, bus.gpu_wren, bus.gpu_clk_en};
  endfunction

  task automatic set_req(input logic [6:0] x, input logic [5:0] y, input logic [6:0] w,
                         input logic [5:0] h, input logic [2:0] ox, input logic [2:0] oy,
                         input logic [7:0] g, input logic [11:0] p, input logic [11:0] s);
    bus.req_x = x; bus.req_y = y; bus.req_w = w; bus.req_h = h;
    bus.req_off_x = ox; bus.req_off_y = oy;
    bus.req_glyph = g; bus.req_primary = p; bus.req_secondary = s;
  endtask

  // Present a request in cycle 0; returns just after the accepting edge (start of cycle 1).
  task automatic send(input logic [6:0] x, input logic [5:0] y, input logic [6:0] w,
                      input logic [5:0] h, input logic [2:0] ox, input logic [2:0] oy,
                      input logic [7:0] g, input logic [11:0] p, input logic [11:0] s);
    @(posedge clk); #1;
    set_req(x, y, w, h, ox, oy, g, p, s);
    bus.req_valid = 1'b1;
    @(negedge clk);
    chk("ready_c0", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Check cycles 1..7n+2 against the expected slot trace, then ready in cycle 7n+3.
  task automatic trace(input string tag, input int n, input logic [31:0] a0,
                       input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] a3, input logic [31:0] dat);
    logic [31:0] al [4];
    logic [31:0] e_ctl, e_addr, e_dat;
    al[0] = a0; al[1] = a1; al[2] = a2; al[3] = a3;
    for (int k = 1; k <= 7*n + 2; k++) begin
      @(negedge clk);
      e_ctl = '0; e_addr = '0; e_dat = '0;
      if (k <= 7*n + 1) e_ctl[10] = 1'b0;
      e_ctl[9] = (k <= 7*n + 1);
      e_ctl[8] = (k == 7*n + 2);
      if (k >= 2 && k <= 7*n + 1) begin
        e_ctl[7]   = 1'b1;
        e_ctl[6:0] = 7'(1 << ((k - 2) % 7));
        e_addr     = al[(k - 2) / 7];
        e_dat      = dat;
      end
      chk($sformatf("%s_ctl_c%0d", tag, k), ctl(), e_ctl);
      chk($sformatf("%s_addr_c%0d", tag, k), bus.gpu_address, e_addr);
      chk($sformatf("%s_data_c%0d", tag, k), bus.gpu_data, e_dat);
    end
    @(negedge clk);
    chk($sformatf("%s_ready_after", tag), ctl(), 32'h400);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    set_req('0, '0, '0, '0, '0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", ctl(), 32'h0);
    chk("rst_addr", bus.gpu_address, 32'h0);
    chk("rst_data", bus.gpu_data, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", ctl(), 32'h400);

    // single block
    send(7'd3, 6'd5, 7'd1, 6'd1, 3'd2, 3'd1, 8'h41, 12'hF00, 12'h00F);
    trace("one", 1, 32'h80003151, 0, 0, 0, 32'h4100FF00);

    // 2x2 row-major
    send(7'd10, 6'd20, 7'd2, 6'd2, 3'd0, 3'd0, 8'h12, 12'h678, 12'h345);
    trace("sq", 4, 32'h8000A500, 32'h8000B500, 32'h8000A540, 32'h8000B540, 32'h12345678);

    // clipped at the bottom-right corner
    send(7'd70, 6'd53, 7'd5, 6'd3, 3'd7, 3'd7, 8'hFF, 12'hDEF, 12'hABC);
    trace("clip", 2, 32'h80046D7F, 32'h80047D7F, 0, 0, 32'hFFABCDEF);

    // empty requests
    send(7'd3, 6'd5, 7'd0, 6'd1, 3'd0, 3'd0, 8'h01, 12'h111, 12'h222);
    trace("w0", 0, 0, 0, 0, 0, 0);
    send(7'd72, 6'd5, 7'd1, 6'd1, 3'd0, 3'd0, 8'h01, 12'h111, 12'h222);
    trace("x72", 0, 0, 0, 0, 0, 0);

    // reset during phase 3 of the second block (cycle 12)
    send(7'd0, 6'd0, 7'd2, 6'd1, 3'd0, 3'd0, 8'h01, 12'h001, 12'h002);
    repeat (11) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_clk_en", {25'b0, bus.gpu_clk_en}, 32'h08);
    chk("mid_addr", bus.gpu_address, 32'h80001000);
    @(negedge clk);
    chk("mid_rst_ctl", ctl(), 32'h0);
    chk("mid_rst_addr", bus.gpu_address, 32'h0);
    chk("mid_rst_data", bus.gpu_data, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_c%0d", k), ctl(), 32'h400);
    end
    send(7'd3, 6'd5, 7'd1, 6'd1, 3'd2, 3'd1, 8'h41, 12'hF00, 12'h00F);
    trace("after_rst", 1, 32'h80003151, 0, 0, 0, 32'h4100FF00);

    // back-pressure: second request held valid through the first
    send(7'd5, 6'd6, 7'd2, 6'd1, 3'd1, 3'd2, 8'h11, 12'h222, 12'h333);
    set_req(7'd9, 6'd9, 7'd1, 6'd1, 3'd3, 3'd4, 8'h77, 12'h0F0, 12'hF0F);
    bus.req_valid = 1'b1;
    trace("bp_a", 2, 32'h8000518A, 32'h8000618A, 0, 0, 32'h11333222);
    @(posedge clk); #1 bus.req_valid = 1'b0;
    trace("bp_b", 1, 32'h8000925C, 0, 0, 0, 32'h77F0F0F0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
